// File: rtl/age_queue_ctrl.sv
// Circular age-order queue controller: allocates at tail, retires at head, rolls back younger entries.
// Latency: all state is registered; effects appear one cycle after acceptance. query_mask and enq_ready are combinational.
// Backpressure: enq_ready drops when full or while rollback_valid is high; dequeue is accepted whenever the queue is non-empty.
//
// Ports:
//   CLK, nRST                     clock, synchronous active-low reset
//   enq_valid/enq_ready/enq_index allocation handshake, enq_index = tail_index
//   deq_valid/deq_ready/deq_index retire handshake, deq_index = head_index
//   rollback_valid/rollback_index discard every entry younger than rollback_index
//   query_index -> query_mask     target mask, bit i set when i > query_index
//   valid_vec, head_index, head_mask, tail_index, count, full, empty  registered state
module age_queue_ctrl #(
    parameter int DEPTH       = 8,
    parameter int INDEX_WIDTH = $clog2(DEPTH),
    parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    output logic [INDEX_WIDTH-1:0] enq_index,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [INDEX_WIDTH-1:0] deq_index,
    input  logic                   rollback_valid,
    input  logic [INDEX_WIDTH-1:0] rollback_index,
    input  logic [INDEX_WIDTH-1:0] query_index,
    output logic [DEPTH-1:0]       query_mask,
    output logic [DEPTH-1:0]       valid_vec,
    output logic [INDEX_WIDTH-1:0] head_index,
    output logic [DEPTH-1:0]       head_mask,
    output logic [INDEX_WIDTH-1:0] tail_index,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   full,
    output logic                   empty
);

    logic [INDEX_WIDTH-1:0] head_q, head_d;
    logic [INDEX_WIDTH-1:0] tail_q, tail_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [DEPTH-1:0]       head_mask_q, head_mask_d;

    logic                   rb_legal;
    logic                   enq_fire;
    logic                   deq_fire;
    logic [INDEX_WIDTH-1:0] rb_span;   // age offset of rollback_index from head
    logic [INDEX_WIDTH-1:0] entry_off; // age offset of entry i from head

    assign full  = (count_q == COUNT_WIDTH'(DEPTH));
    assign empty = (count_q == '0);

    assign enq_ready  = ~full & ~rollback_valid;
    assign enq_index  = tail_q;
    assign deq_valid  = ~empty;
    assign deq_index  = head_q;
    assign valid_vec  = valid_q;
    assign head_index = head_q;
    assign head_mask  = head_mask_q;
    assign tail_index = tail_q;
    assign count      = count_q;

    // Rollback to an entry that is not currently allocated is dropped silently.
    assign rb_legal = rollback_valid & valid_q[rollback_index];
    assign enq_fire = enq_valid & enq_ready;
    assign deq_fire = deq_ready & ~empty;
    // DEPTH is a power of two, so the index subtraction wraps modulo DEPTH.
    assign rb_span  = rollback_index - head_q;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        valid_d   = valid_q;
        entry_off = '0;

        // Rollback and enqueue are mutually exclusive because enq_ready is low during rollback_valid.
        if (rb_legal) begin
            tail_d  = rollback_index + INDEX_WIDTH'(1);
            count_d = COUNT_WIDTH'(rb_span) + COUNT_WIDTH'(1);
            for (int i = 0; i < DEPTH; i++) begin
                entry_off = INDEX_WIDTH'(i) - head_q;
                if (entry_off > rb_span) begin
                    valid_d[i] = 1'b0;
                end
            end
        end else if (enq_fire) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + INDEX_WIDTH'(1);
            count_d         = count_q + COUNT_WIDTH'(1);
        end

        // Dequeue applies on top of a same-cycle rollback; the head entry always survives rollback.
        if (deq_fire) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + INDEX_WIDTH'(1);
            count_d         = count_d - COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        head_mask_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            head_mask_d[i] = (INDEX_WIDTH'(i) >= head_d);
        end
    end

    always_comb begin
        query_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            query_mask[i] = (INDEX_WIDTH'(i) > query_index);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            valid_q     <= '0;
            head_mask_q <= '1;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            head_mask_q <= head_mask_d;
        end
    end

endmodule

// File: tb/tb_age_queue_ctrl.sv
module tb_age_queue_ctrl;

    localparam int D  = 8;
    localparam int IW = 3;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          enq_valid;
    logic          enq_ready;
    logic [IW-1:0] enq_index;
    logic          deq_valid;
    logic          deq_ready;
    logic [IW-1:0] deq_index;
    logic          rollback_valid;
    logic [IW-1:0] rollback_index;
    logic [IW-1:0] query_index;
    logic [D-1:0]  query_mask;
    logic [D-1:0]  valid_vec;
    logic [IW-1:0] head_index;
    logic [D-1:0]  head_mask;
    logic [IW-1:0] tail_index;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    always #5 CLK = ~CLK;

    age_queue_ctrl #(.DEPTH(D)) dut (
        .CLK(CLK), .nRST(nRST),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_index(enq_index),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_index(deq_index),
        .rollback_valid(rollback_valid), .rollback_index(rollback_index),
        .query_index(query_index), .query_mask(query_mask),
        .valid_vec(valid_vec), .head_index(head_index), .head_mask(head_mask),
        .tail_index(tail_index), .count(count), .full(full), .empty(empty)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: occupied indices in age order, oldest first.
    int mq[$];
    int m_head = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_tail();
        return (m_head + mq.size()) % D;
    endfunction

    function automatic logic [D-1:0] m_valid();
        logic [D-1:0] v = '0;
        foreach (mq[k]) v[mq[k]] = 1'b1;
        return v;
    endfunction

    function automatic logic [D-1:0] m_hmask();
        logic [D-1:0] v = '0;
        for (int i = 0; i < D; i++) v[i] = (i >= m_head);
        return v;
    endfunction

    function automatic logic [D-1:0] m_qmask(input int q);
        logic [D-1:0] v = '0;
        for (int i = 0; i < D; i++) v[i] = (i > q);
        return v;
    endfunction

    task automatic check_outputs();
        chk("head_index", 32'(head_index), 32'(m_head));
        chk("deq_index",  32'(deq_index),  32'(m_head));
        chk("tail_index", 32'(tail_index), 32'(m_tail()));
        chk("enq_index",  32'(enq_index),  32'(m_tail()));
        chk("count",      32'(count),      32'(mq.size()));
        chk("full",       32'(full),       32'(mq.size() == D));
        chk("empty",      32'(empty),      32'(mq.size() == 0));
        chk("deq_valid",  32'(deq_valid),  32'(mq.size() != 0));
        chk("valid_vec",  32'(valid_vec),  32'(m_valid()));
        chk("head_mask",  32'(head_mask),  32'(m_hmask()));
        chk("enq_ready",  32'(enq_ready),  32'((mq.size() < D) && !rollback_valid));
        chk("query_mask", 32'(query_mask), 32'(m_qmask(int'(query_index))));
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, update model, check after edge.
    task automatic step(input bit rst_n, input bit enq, input bit deq, input bit rb,
                        input int rbi, input int qi);
        int pos;
        bit enq_fire, deq_fire;
        @(negedge CLK);
        nRST           = rst_n;
        enq_valid      = enq;
        deq_ready      = deq;
        rollback_valid = rb;
        rollback_index = IW'(rbi);
        query_index    = IW'(qi);
        #1;
        chk("enq_ready_comb",  32'(enq_ready),  32'((mq.size() < D) && !rb));
        chk("query_mask_comb", 32'(query_mask), 32'(m_qmask(qi)));
        if (!rst_n) begin
            mq.delete();
            m_head = 0;
        end else begin
            enq_fire = enq && (mq.size() < D) && !rb;
            deq_fire = deq && (mq.size() > 0);
            pos = -1;
            if (rb) foreach (mq[k]) if (mq[k] == rbi) pos = k;
            if (pos >= 0) while (mq.size() > pos + 1) void'(mq.pop_back());
            if (enq_fire) mq.push_back(m_tail());
            if (deq_fire) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % D;
            end
        end
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    initial begin
        nRST = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        rollback_valid = 1'b0; rollback_index = '0; query_index = '0;
        repeat (2) @(posedge CLK);
        #1;
        mq.delete();
        m_head = 0;
        check_outputs();
        chk("rst_head_mask_lit", 32'(head_mask), 32'hFF);
        chk("rst_empty_lit", 32'(empty), 32'd1);

        // Fill: enq_index walks 0..7, then full.
        for (int i = 0; i < D; i++) begin
            chk("enq_index_fill", 32'(enq_index), 32'(i));
            step(1, 1, 0, 0, 0, $urandom_range(0, D-1));
        end
        chk("full_lit", 32'(full), 32'd1);
        chk("valid_full_lit", 32'(valid_vec), 32'hFF);
        chk("count_full_lit", 32'(count), 32'd8);
        chk("enq_ready_full_lit", 32'(enq_ready), 32'd0);
        step(1, 1, 0, 0, 0, 0); // enqueue refused while full

        // Three retires then three allocations wrapping the tail.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("enq_index_wrap", 32'(enq_index), 32'(i));
            step(1, 1, 0, 0, 0, 0);
        end
        chk("head_wrap_lit", 32'(head_index), 32'd3);
        chk("head_mask_wrap_lit", 32'(head_mask), 32'hF8);
        chk("tail_wrap_lit", 32'(tail_index), 32'd3);
        chk("full_wrap_lit", 32'(full), 32'd1);

        // Reach head=6 with 6,7,0,1,2 valid; rollback to 7 while enq_valid is high.
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 7, 0);
        chk("rb7_valid_lit", 32'(valid_vec), 32'hC0);
        chk("rb7_tail_lit", 32'(tail_index), 32'd0);
        chk("rb7_count_lit", 32'(count), 32'd2);

        // Restore 6,7,0,1,2 and try an illegal rollback.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 4, 5);
        chk("rb_illegal_count_lit", 32'(count), 32'd5);
        chk("rb_illegal_valid_lit", 32'(valid_vec), 32'hC7);
        chk("qmask5_lit", 32'(query_mask), 32'hC0);
        step(1, 0, 0, 0, 0, 7);
        chk("qmask7_lit", 32'(query_mask), 32'h00);

        // Rollback to head with a same-cycle dequeue empties the queue.
        step(1, 0, 1, 1, 6, 0);
        chk("rbhead_empty_lit", 32'(empty), 32'd1);
        chk("rbhead_head_lit", 32'(head_index), 32'd7);
        chk("rbhead_tail_lit", 32'(tail_index), 32'd7);
        chk("rbhead_valid_lit", 32'(valid_vec), 32'h00);

        // Reset mid-stream with rollback and dequeue active.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        chk("midrst_head_lit", 32'(head_index), 32'd0);
        chk("midrst_count_lit", 32'(count), 32'd0);
        chk("midrst_mask_lit", 32'(head_mask), 32'hFF);
        chk("midrst_valid_lit", 32'(valid_vec), 32'h00);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            bit r_rst, r_enq, r_deq, r_rb;
            int r_idx;
            r_rst = ($urandom_range(0, 199) == 0);
            r_enq = ($urandom_range(0, 3) != 0);
            r_deq = ($urandom_range(0, 2) == 0);
            r_rb  = ($urandom_range(0, 7) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                r_idx = mq[$urandom_range(0, mq.size() - 1)];
            else
                r_idx = $urandom_range(0, D - 1);
            step(!r_rst, r_enq, r_deq, r_rb, r_idx, $urandom_range(0, D - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
